// File: rtl/adc_sample_conditioner.sv
// adc_sample_conditioner: source select, saturating offset, clip flag and capture-window statistics
module adc_sample_conditioner #(
    parameter int pDATA_WIDTH     = 12,
    parameter int pCLIP_CNT_WIDTH = 16
) (
    input  logic                       adc_sampleclk,
    input  logic                       reset,
    input  logic [pDATA_WIDTH-1:0]     adc_data_i,
    input  logic [1:0]                 source_sel_i,
    input  logic [pDATA_WIDTH-1:0]     test_value_i,
    input  logic [pDATA_WIDTH:0]       offset_i,
    input  logic                       capture_active_i,
    input  logic                       clear_stats_i,
    output logic [pDATA_WIDTH-1:0]     data_o,
    output logic                       clip_o,
    output logic                       clip_sticky_o,
    output logic [pCLIP_CNT_WIDTH-1:0] clip_count_o,
    output logic [pDATA_WIDTH-1:0]     min_o,
    output logic [pDATA_WIDTH-1:0]     max_o
);
    logic [pDATA_WIDTH-1:0]     r_ramp;
    logic                       r_tog;
    logic [pDATA_WIDTH-1:0]     r_s1_data;
    logic                       r_s1_clip;
    logic                       r_s1_act;
    logic [pDATA_WIDTH-1:0]     r_data;
    logic                       r_clip;
    logic                       r_s2_act;
    logic                       r_sticky;
    logic [pCLIP_CNT_WIDTH-1:0] r_cnt;
    logic [pDATA_WIDTH-1:0]     r_min;
    logic [pDATA_WIDTH-1:0]     r_max;
    logic [pDATA_WIDTH-1:0]     w_src;
    logic                       w_src_clip;
    logic [pDATA_WIDTH+1:0]     w_sum;
    logic [pDATA_WIDTH-1:0]     w_sat;

    // Source mux, clip detect on the raw source, and offset add clamped to the unsigned sample range
    always_comb begin
        w_src      = source_sel_i == 2'd0 ? adc_data_i :
                     source_sel_i == 2'd1 ? r_ramp :
                     source_sel_i == 2'd2 ? test_value_i :
                     (r_tog ? ~test_value_i : test_value_i);
        w_src_clip = (w_src == '0) || (w_src == '1);
        w_sum      = {2'b00, r_s1_data} + {offset_i[pDATA_WIDTH], offset_i};
        w_sat      = w_sum[pDATA_WIDTH+1] ? '0 : w_sum[pDATA_WIDTH] ? '1 : w_sum[pDATA_WIDTH-1:0];
    end

    // Free-running ramp and alternate toggle, independent of the selected source
    always_ff @(posedge adc_sampleclk or posedge reset) begin
        if (reset) begin
            r_ramp <= '0;
            r_tog  <= 1'b0;
        end else begin
            r_ramp <= r_ramp + 1'b1;
            r_tog  <= ~r_tog;
        end
    end

    // Two-register data pipeline; the window flag travels with its sample
    always_ff @(posedge adc_sampleclk or posedge reset) begin
        if (reset) begin
            r_s1_data <= '0;
            r_s1_clip <= 1'b0;
            r_s1_act  <= 1'b0;
            r_data    <= '0;
            r_clip    <= 1'b0;
            r_s2_act  <= 1'b0;
        end else begin
            r_s1_data <= w_src;
            r_s1_clip <= w_src_clip;
            r_s1_act  <= capture_active_i;
            r_data    <= w_sat;
            r_clip    <= r_s1_clip;
            r_s2_act  <= r_s1_act;
        end
    end

    // Window statistics on the presented sample; clear wins over a coincident sample
    always_ff @(posedge adc_sampleclk or posedge reset) begin
        if (reset || clear_stats_i) begin
            r_min    <= '1;
            r_max    <= '0;
            r_sticky <= 1'b0;
            r_cnt    <= '0;
        end else if (r_s2_act) begin
            r_min    <= r_data < r_min ? r_data : r_min;
            r_max    <= r_data > r_max ? r_data : r_max;
            r_sticky <= r_sticky | r_clip;
            r_cnt    <= (r_clip && r_cnt != '1) ? r_cnt + 1'b1 : r_cnt;
        end
    end

    assign data_o        = r_data;
    assign clip_o        = r_clip;
    assign clip_sticky_o = r_sticky;
    assign clip_count_o  = r_cnt;
    assign min_o         = r_min;
    assign max_o         = r_max;
endmodule
